hlsm_checker: RTL and testbench

HLSM_CHECKER -- requirements
Module: hlsm_checker

---
 rtl/hlsm_checker.sv | 132 +++++++++++++
 tb/tb_hlsm_checker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hlsm_checker.sv
// hlsm_checker: compares a DUT against a reference model per transaction.
// Checks Start-to-Done latency, output data, Done agreement, timeouts and protocol.
// Ports:
//   Clk, Rst                 clock, synchronous active-high reset
//   Start, Done, DoneRef     DUT start, DUT completion, reference completion
//   DutData, RefData         NUM_OUT packed channels of DATAWIDTH bits each
//   Busy                     transaction open
//   DataErr, LatErr, DoneErr, TimeoutErr, ProtoErr   one-cycle error pulses
//   ErrMask                  mismatching channels of the most recent close
//   Err                      sticky OR of all error pulses
//   ErrCount, PassCount      saturating error-cycle and passing-close counters
//   LastLatency              latency of the most recent close
module hlsm_checker #(
    parameter int DATAWIDTH = 32,
    parameter int NUM_OUT   = 2,
    parameter int LATENCY   = 6,
    parameter int LAT_MODE  = 0,
    parameter int TIMEOUT   = 64
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           Start,
    input  logic                           Done,
    input  logic                           DoneRef,
    input  logic [NUM_OUT*DATAWIDTH-1:0]   DutData,
    input  logic [NUM_OUT*DATAWIDTH-1:0]   RefData,
    output logic                           Busy,
    output logic                           DataErr,
    output logic [NUM_OUT-1:0]             ErrMask,
    output logic                           LatErr,
    output logic                           DoneErr,
    output logic                           TimeoutErr,
    output logic                           ProtoErr,
    output logic                           Err,
    output logic [15:0]                    ErrCount,
    output logic [15:0]                    PassCount,
    output logic [15:0]                    LastLatency
);
    localparam logic [15:0] LAT = 16'(LATENCY);
    localparam logic [15:0] TMO = 16'(TIMEOUT);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_n;
    logic [15:0]        cnt, cnt_n;
    logic [NUM_OUT-1:0] mism;
    logic               close, lat_bad, proto_n, tmo_n, data_n, lat_n, done_n, any_n;

    always_comb begin
        mism = '0;
        for (int i = 0; i < NUM_OUT; i++)
            mism[i] = DutData[i*DATAWIDTH +: DATAWIDTH] != RefData[i*DATAWIDTH +: DATAWIDTH];
    end

    // A close is any Done seen while a transaction is open, with or without a new Start.
    assign close   = (state == RUN) && Done;
    assign lat_bad = (LAT_MODE == 0) ? (cnt != LAT) : (cnt > LAT);
    assign data_n  = close && |mism;
    assign lat_n   = close && lat_bad;
    assign done_n  = Done != DoneRef;
    assign any_n   = data_n | lat_n | done_n | tmo_n | proto_n;
    assign Busy    = state == RUN;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Start while open restarts the count; a Start coinciding with Done is a
    // legal back-to-back transaction, without Done it abandons the old one.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        proto_n = 1'b0;
        tmo_n   = 1'b0;
        if (state == IDLE) begin
            proto_n = Done;
            if (Start) begin
                state_n = RUN;
                cnt_n   = 16'd1;
            end
        end else if (Start) begin
            proto_n = !Done;
            cnt_n   = 16'd1;
        end else if (Done) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (cnt == TMO) begin
            tmo_n   = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            cnt_n = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            DataErr     <= 1'b0;
            LatErr      <= 1'b0;
            DoneErr     <= 1'b0;
            TimeoutErr  <= 1'b0;
            ProtoErr    <= 1'b0;
            ErrMask     <= '0;
            Err         <= 1'b0;
            ErrCount    <= '0;
            PassCount   <= '0;
            LastLatency <= '0;
        end else begin
            DataErr    <= data_n;
            LatErr     <= lat_n;
            DoneErr    <= done_n;
            TimeoutErr <= tmo_n;
            ProtoErr   <= proto_n;
            if (close) begin
                ErrMask     <= mism;
                LastLatency <= cnt;
            end
            if (close && !lat_bad && !(|mism) && PassCount != 16'hFFFF)
                PassCount <= PassCount + 16'd1;
            if (any_n)
                Err <= 1'b1;
            if (any_n && ErrCount != 16'hFFFF)
                ErrCount <= ErrCount + 16'd1;
        end
    end
endmodule

// File: tb/tb_hlsm_checker.sv
// tb_hlsm_checker: directed and random checks of two hlsm_checker instances
// (exact-latency and at-most-latency modes) against a timestamp-based model.
module tb_hlsm_checker;
    localparam int LAT = 6;
    localparam int TMO = 64;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Start = 1'b0;
    logic        Done = 1'b0;
    logic        DoneRef = 1'b0;
    logic [63:0] DutData = '0;
    logic [63:0] RefData = '0;

    logic        busy [2];
    logic        data_err [2];
    logic [1:0]  mask [2];
    logic        lat_err [2];
    logic        done_err [2];
    logic        tmo_err [2];
    logic        proto_err [2];
    logic        err [2];
    logic [15:0] err_cnt [2];
    logic [15:0] pass_cnt [2];
    logic [15:0] last_lat [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        hlsm_checker #(
            .DATAWIDTH(32), .NUM_OUT(2), .LATENCY(LAT), .LAT_MODE(g), .TIMEOUT(TMO)
        ) u_dut (
            .Clk(Clk), .Rst(Rst), .Start(Start), .Done(Done), .DoneRef(DoneRef),
            .DutData(DutData), .RefData(RefData),
            .Busy(busy[g]), .DataErr(data_err[g]), .ErrMask(mask[g]), .LatErr(lat_err[g]),
            .DoneErr(done_err[g]), .TimeoutErr(tmo_err[g]), .ProtoErr(proto_err[g]),
            .Err(err[g]), .ErrCount(err_cnt[g]), .PassCount(pass_cnt[g]),
            .LastLatency(last_lat[g])
        );
    end

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int t = 0;

    bit          m_open [2];
    int          m_ts [2];
    logic        e_data [2], e_lat [2], e_done [2], e_tmo [2], e_proto [2], e_err [2];
    logic [1:0]  e_mask [2];
    logic [15:0] e_errcnt [2], e_pass [2], e_last [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: a transaction is remembered by the edge index it opened on;
    // its latency at any edge is simply the distance between the two edges.
    task automatic model(input logic s, d, dr, r, input logic [63:0] dd, rd);
        for (int m = 0; m < 2; m++) begin
            bit closed = 0;
            int lat = 0;
            logic [1:0] mm;
            if (r) begin
                m_open[m] = 0;
                {e_data[m], e_lat[m], e_done[m], e_tmo[m], e_proto[m], e_err[m]} = '0;
                e_mask[m] = '0; e_errcnt[m] = '0; e_pass[m] = '0; e_last[m] = '0;
                continue;
            end
            {e_data[m], e_lat[m], e_tmo[m], e_proto[m]} = '0;
            e_done[m] = d != dr;
            if (!m_open[m]) begin
                e_proto[m] = d;
                if (s) begin m_open[m] = 1; m_ts[m] = t; end
            end else begin
                lat = t - m_ts[m];
                if (d) begin
                    closed = 1;
                    if (s) m_ts[m] = t; else m_open[m] = 0;
                end else if (s) begin
                    e_proto[m] = 1;
                    m_ts[m] = t;
                end else if (lat >= TMO) begin
                    e_tmo[m] = 1;
                    m_open[m] = 0;
                end
            end
            if (closed) begin
                mm = {dd[63:32] != rd[63:32], dd[31:0] != rd[31:0]};
                e_mask[m] = mm;
                e_last[m] = 16'(lat);
                e_data[m] = mm != 0;
                e_lat[m] = (m == 0) ? (lat != LAT) : (lat > LAT);
                if (!e_data[m] && !e_lat[m] && e_pass[m] != 16'hFFFF) e_pass[m]++;
            end
            if (e_data[m] | e_lat[m] | e_done[m] | e_tmo[m] | e_proto[m]) begin
                e_err[m] = 1;
                if (e_errcnt[m] != 16'hFFFF) e_errcnt[m]++;
            end
        end
    endtask

    task automatic step(input logic s, d, dr, r, input logic [63:0] dd, rd);
        Start = s; Done = d; DoneRef = dr; Rst = r; DutData = dd; RefData = rd;
        @(posedge Clk);
        t++;
        model(s, d, dr, r, dd, rd);
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("m%0d t%0d Busy", m, t), 32'(busy[m]), 32'(m_open[m]));
            chk($sformatf("m%0d t%0d DataErr", m, t), 32'(data_err[m]), 32'(e_data[m]));
            chk($sformatf("m%0d t%0d ErrMask", m, t), 32'(mask[m]), 32'(e_mask[m]));
            chk($sformatf("m%0d t%0d LatErr", m, t), 32'(lat_err[m]), 32'(e_lat[m]));
            chk($sformatf("m%0d t%0d DoneErr", m, t), 32'(done_err[m]), 32'(e_done[m]));
            chk($sformatf("m%0d t%0d TimeoutErr", m, t), 32'(tmo_err[m]), 32'(e_tmo[m]));
            chk($sformatf("m%0d t%0d ProtoErr", m, t), 32'(proto_err[m]), 32'(e_proto[m]));
            chk($sformatf("m%0d t%0d Err", m, t), 32'(err[m]), 32'(e_err[m]));
            chk($sformatf("m%0d t%0d ErrCount", m, t), 32'(err_cnt[m]), 32'(e_errcnt[m]));
            chk($sformatf("m%0d t%0d PassCount", m, t), 32'(pass_cnt[m]), 32'(e_pass[m]));
            chk($sformatf("m%0d t%0d LastLatency", m, t), 32'(last_lat[m]), 32'(e_last[m]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0);
    endtask

    initial begin
        logic [63:0] dd, rd;
        // reset and default state
        step(0, 0, 0, 1, '0, '0);
        step(1, 1, 0, 1, '0, '0);
        chk("reset Busy", 32'(busy[0]), 32'd0);
        chk("reset ErrCount", 32'(err_cnt[0]), 32'd0);
        idle(2);
        // nominal transaction of latency 6
        step(1, 0, 0, 0, '0, '0);
        idle(LAT - 1);
        step(0, 1, 1, 0, 64'h1234_5678_9abc_def0, 64'h1234_5678_9abc_def0);
        chk("nominal LastLatency", 32'(last_lat[0]), 32'd6);
        chk("nominal PassCount", 32'(pass_cnt[0]), 32'd1);
        chk("nominal Err", 32'(err[0]), 32'd0);
        idle(2);
        // early Done: latency 5
        step(1, 0, 0, 0, '0, '0);
        idle(LAT - 2);
        step(0, 1, 1, 0, '0, '0);
        chk("early LatErr m0", 32'(lat_err[0]), 32'd1);
        chk("early LastLatency", 32'(last_lat[0]), 32'd5);
        chk("early ErrCount m0", 32'(err_cnt[0]), 32'd1);
        chk("early LatErr m1", 32'(lat_err[1]), 32'd0);
        chk("early PassCount m1", 32'(pass_cnt[1]), 32'd2);
        idle(2);
        // channel 1 mismatch
        step(1, 0, 0, 0, '0, '0);
        idle(LAT - 1);
        step(0, 1, 1, 0, {32'h5, 32'h7}, {32'h4, 32'h7});
        chk("data DataErr", 32'(data_err[1]), 32'd1);
        chk("data ErrMask", 32'(mask[1]), 32'd2);
        idle(3);
        chk("data ErrMask held", 32'(mask[1]), 32'd2);
        chk("data Err sticky", 32'(err[1]), 32'd1);
        // timeout, then a stray Done
        step(1, 0, 0, 0, '0, '0);
        idle(TMO - 1);
        chk("pre-timeout Busy", 32'(busy[0]), 32'd1);
        idle(1);
        chk("timeout TimeoutErr", 32'(tmo_err[0]), 32'd1);
        chk("timeout Busy", 32'(busy[0]), 32'd0);
        idle(2);
        step(0, 1, 1, 0, '0, '0);
        chk("stray Done ProtoErr", 32'(proto_err[0]), 32'd1);
        idle(1);
        // back-to-back Done+Start, then Start without Done
        step(1, 0, 0, 0, '0, '0);
        idle(LAT - 1);
        step(1, 1, 1, 0, '0, '0);
        chk("b2b Busy", 32'(busy[0]), 32'd1);
        chk("b2b ProtoErr", 32'(proto_err[0]), 32'd0);
        idle(LAT - 1);
        step(0, 1, 1, 0, '0, '0);
        chk("b2b second LatErr", 32'(lat_err[0]), 32'd0);
        step(1, 0, 0, 0, '0, '0);
        idle(2);
        step(1, 0, 0, 0, '0, '0);
        chk("restart ProtoErr", 32'(proto_err[0]), 32'd1);
        idle(LAT);
        // Done without DoneRef, then reset mid-transaction
        step(0, 1, 0, 0, '0, '0);
        chk("DoneErr pulse", 32'(done_err[0]), 32'd1);
        step(1, 0, 0, 0, '0, '0);
        idle(3);
        step(0, 1, 1, 1, '0, '1);
        chk("reset Busy mid", 32'(busy[0]), 32'd0);
        chk("reset Err mid", 32'(err[0]), 32'd0);
        idle(2);
        // random traffic
        for (int i = 0; i < 2500; i++) begin
            dd = {$urandom, $urandom};
            rd = ($urandom_range(0, 3) == 0) ? dd ^ (64'h1 << $urandom_range(0, 63)) : dd;
            Done = ($urandom_range(0, 5) == 0);
            step($urandom_range(0, 11) == 0, Done,
                 ($urandom_range(0, 15) == 0) ? !Done : Done,
                 $urandom_range(0, 299) == 0, dd, rd);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
